// File: rtl/accel_tile_writeback_pkg.sv
// Shared types and helpers for the tile write-back engine.
package accel_tile_writeback_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TILE = 3'd1,
        S_AW   = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5
    } wb_state_e;

    // log2 of the MIG beat size in bytes; addresses must be aligned to this.
    function automatic int mig_byte_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/accel_tile_writeback_elem_reverse.sv
// Combinational element-order reversal within one MIG beat.
module accel_elem_reverse #(
    parameter int DATA_WIDTH = 512,
    parameter int ELEM_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    localparam int NUM_ELEMS = DATA_WIDTH / ELEM_WIDTH;

    // Element i of the output is element NUM_ELEMS-1-i of the input.
    for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_elem
        assign data_o[i*ELEM_WIDTH +: ELEM_WIDTH] = data_i[(NUM_ELEMS-1-i)*ELEM_WIDTH +: ELEM_WIDTH];
    end

endmodule

// File: rtl/accel_tile_writeback.sv
// Multi-tile result write-back engine: captures tiles and writes them as AW/W/B bursts.
//
// state  | meaning
// S_IDLE | waiting for start_i
// S_TILE | tile_ready_o high, waiting for a tile from the array
// S_AW   | presenting burst address
// S_W    | streaming the beats of the current burst
// S_B    | waiting for the write response of the current burst
// S_DONE | one-cycle done pulse
module accel_tile_writeback
    import accel_tile_writeback_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 512,
    parameter int ELEM_WIDTH    = 16,
    parameter int TILE_WIDTH    = 4096,
    parameter int BURST_BEATS   = 8,
    parameter int MAX_TILES     = 256,
    parameter int REVERSE_ELEMS = 1,
    localparam int CNT_W        = $clog2(MAX_TILES) + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH-1:0]   tile_stride_i,
    input  logic [CNT_W-1:0]        num_tiles_i,
    input  logic [TILE_WIDTH-1:0]   tile_i,
    input  logic                    tile_valid_i,
    output logic                    tile_ready_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [CNT_W-1:0]        tiles_written_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic [7:0]              awlen_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o
);
    localparam int BEATS  = TILE_WIDTH / DATA_WIDTH;
    localparam int BURSTS = BEATS / BURST_BEATS;
    localparam int SHIFT  = mig_byte_shift(DATA_WIDTH);
    localparam int BCW    = $clog2(BURSTS) + 1;
    localparam logic [BCW-1:0]        BURSTS_M1   = BCW'(BURSTS - 1);
    localparam logic [7:0]            AWLEN       = 8'(BURST_BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_BEATS * (DATA_WIDTH / 8));

    if (TILE_WIDTH % DATA_WIDTH != 0) begin : g_bad_tile_width
        $error("TILE_WIDTH must be a multiple of DATA_WIDTH");
    end
    if (BEATS % BURST_BEATS != 0) begin : g_bad_burst_beats
        $error("BURST_BEATS must divide TILE_WIDTH/DATA_WIDTH");
    end
    if (BURST_BEATS > 256) begin : g_burst_too_long
        $error("BURST_BEATS must not exceed 256");
    end

    wb_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]     stride_q, tile_addr_q, burst_addr_q;
    logic [CNT_W-1:0]          tiles_left_q, written_q;
    logic [BCW-1:0]            bursts_left_q;
    logic [7:0]                beats_left_q;
    logic [TILE_WIDTH-1:0]     hold_q;
    logic                      err_q;

    logic                      misaligned, start_skip, start_acc;
    logic                      tile_hs, aw_hs, w_hs, b_hs;
    logic [DATA_WIDTH-1:0]     beat, beat_rev, beat_out;

    assign misaligned = (base_addr_i[SHIFT-1:0] != '0) || (tile_stride_i[SHIFT-1:0] != '0);
    assign start_skip = (num_tiles_i == '0) || misaligned;
    assign start_acc  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    assign tile_hs = tile_ready_o & tile_valid_i;
    assign aw_hs   = awvalid_o & awready_i;
    assign w_hs    = wvalid_o & wready_i;
    assign b_hs    = bready_o & bvalid_i;

    // The hold register shifts up one beat per W handshake, so the current beat is always the top slice.
    assign beat = hold_q[TILE_WIDTH-1 -: DATA_WIDTH];

    accel_elem_reverse #(
        .DATA_WIDTH (DATA_WIDTH),
        .ELEM_WIDTH (ELEM_WIDTH)
    ) u_elem_reverse (
        .data_i (beat),
        .data_o (beat_rev)
    );

    assign beat_out        = (REVERSE_ELEMS != 0) ? beat_rev : beat;
    assign wdata_o         = wvalid_o ? beat_out : '0;
    assign wstrb_o         = wvalid_o ? '1 : '0;
    assign wlast_o         = wvalid_o && (beats_left_q == '0);
    assign awaddr_o        = awvalid_o ? burst_addr_q : '0;
    assign awlen_o         = awvalid_o ? AWLEN : '0;
    assign err_o           = err_q;
    assign tiles_written_o = written_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        tile_ready_o = 1'b0;
        awvalid_o    = 1'b0;
        wvalid_o     = 1'b0;
        bready_o     = 1'b0;
        done_o       = 1'b0;
        busy_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = start_skip ? S_DONE : S_TILE;
            end
            S_TILE: begin
                busy_o       = 1'b1;
                tile_ready_o = 1'b1;
                if (tile_valid_i) state_d = S_AW;
            end
            S_AW: begin
                busy_o    = 1'b1;
                awvalid_o = 1'b1;
                if (awready_i) state_d = S_W;
            end
            S_W: begin
                busy_o   = 1'b1;
                wvalid_o = 1'b1;
                if (wready_i && (beats_left_q == '0)) state_d = S_B;
            end
            S_B: begin
                busy_o   = 1'b1;
                bready_o = 1'b1;
                if (bvalid_i) begin
                    if (bursts_left_q != '0)     state_d = S_AW;
                    else if (tiles_left_q == '0) state_d = S_DONE;
                    else                         state_d = S_TILE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
                if (start_i) state_d = start_skip ? S_DONE : S_TILE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Job parameters, down-counters, tile holding register and status.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stride_q      <= '0;
            tile_addr_q   <= '0;
            burst_addr_q  <= '0;
            tiles_left_q  <= '0;
            written_q     <= '0;
            bursts_left_q <= '0;
            beats_left_q  <= '0;
            hold_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            if (start_acc) begin
                stride_q     <= tile_stride_i;
                tile_addr_q  <= base_addr_i;
                tiles_left_q <= num_tiles_i - CNT_W'(1);
                written_q    <= '0;
                err_q        <= misaligned;
            end
            if (tile_hs) begin
                hold_q        <= tile_i;
                burst_addr_q  <= tile_addr_q;
                bursts_left_q <= BURSTS_M1;
                beats_left_q  <= AWLEN;
            end
            if (aw_hs) begin
                beats_left_q <= AWLEN;
            end
            if (w_hs) begin
                hold_q       <= hold_q << DATA_WIDTH;
                beats_left_q <= beats_left_q - 8'd1;
            end
            if (b_hs) begin
                if (bresp_i != 2'b00) err_q <= 1'b1;
                if (bursts_left_q != '0) begin
                    bursts_left_q <= bursts_left_q - BCW'(1);
                    burst_addr_q  <= burst_addr_q + BURST_BYTES;
                end else begin
                    written_q    <= written_q + CNT_W'(1);
                    tile_addr_q  <= tile_addr_q + stride_q;
                    tiles_left_q <= tiles_left_q - CNT_W'(1);
                end
            end
        end
    end

endmodule
